// File: rtl/seq_datapath.sv
// -----------------------------------------------------------------------------
// seq_datapath
//   Register-file datapath with A/B/C operand registers, a one-bit shifter,
//   a four-function ALU and Z/N/V status flags, driven by an internal
//   micro-sequencer. The controller hands over a complete operation with a
//   single start pulse. The sequencer then runs
//   IDLE -> LOAD_A -> LOAD_B -> EXEC -> WB and pulses done once on return.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             operation request, accepted only while idle
//   rd, rn, rm        destination / operand-A / operand-B register indices
//   shift_op          00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
//   alu_op            00 ADD, 01 SUB, 10 AND, 11 NOT-B
//   use_imm           B operand = sign-extended imm5 instead of shifted B
//   zero_a            A operand forced to zero
//   wb_sel            write-back source: 00 C, 01 pc, 10 imm8, 11 mdata
//   wr_en, upd_status enable register write-back / flag update
//   imm5, imm8, pc, mdata  operand and write-back sources
//   busy, done        sequencer in progress / one-cycle completion pulse
//   result            C register
//   Z_out/N_out/V_out status flags
//   dbg_addr, dbg_data combinational debug read of the register file
// -----------------------------------------------------------------------------
module seq_datapath #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int PC_W   = 8,
  parameter int IMM5_W = 5,
  parameter int IMM8_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [$clog2(NREGS)-1:0] rm,
  input  logic [1:0]               shift_op,
  input  logic [1:0]               alu_op,
  input  logic                     use_imm,
  input  logic                     zero_a,
  input  logic [1:0]               wb_sel,
  input  logic                     wr_en,
  input  logic                     upd_status,
  input  logic [IMM5_W-1:0]        imm5,
  input  logic [IMM8_W-1:0]        imm8,
  input  logic [PC_W-1:0]          pc,
  input  logic [WIDTH-1:0]         mdata,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     Z_out,
  output logic                     N_out,
  output logic                     V_out,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB
  } state_t;

  // Everything the controller supplies with start, captured in one go so
  // later changes on the inputs cannot disturb an operation in flight.
  typedef struct packed {
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rn;
    logic [AW-1:0]     rm;
    logic [1:0]        shift_op;
    logic [1:0]        alu_op;
    logic              use_imm;
    logic              zero_a;
    logic [1:0]        wb_sel;
    logic              wr_en;
    logic              upd_status;
    logic [IMM5_W-1:0] imm5;
    logic [IMM8_W-1:0] imm8;
    logic [PC_W-1:0]   pc;
    logic [WIDTH-1:0]  mdata;
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             z_q, z_d, n_q, n_d, v_q, v_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] regs_q [NREGS];

  // ---------------------------------------------------------------------------
  // Operand preparation, ALU and write-back mux
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a, op_b, b_shifted, alu_res, wb_val;
  logic             alu_v;

  assign op_a = op_q.zero_a ? '0 : a_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    b_shifted = b_q;
    unique case (op_q.shift_op)
      2'b00: b_shifted = b_q;
      2'b01: b_shifted = {b_q[WIDTH-2:0], 1'b0};
      2'b10: b_shifted = {1'b0, b_q[WIDTH-1:1]};
      2'b11: b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
    endcase
  end

  assign op_b = op_q.use_imm ? WIDTH'($signed(op_q.imm5)) : b_shifted;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (op_q.alu_op)
      2'b00: begin
        alu_res = op_a + op_b;
        // Overflow when both operands share a sign the sum does not.
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b01: begin
        alu_res = op_a - op_b;
        // Overflow when operand signs differ and the difference takes B's sign.
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b10: alu_res = op_a & op_b;
      2'b11: alu_res = ~op_b;
    endcase
  end

  always_comb begin
    wb_val = c_q;
    unique case (op_q.wb_sel)
      2'b00: wb_val = c_q;
      2'b01: wb_val = WIDTH'(op_q.pc);
      2'b10: wb_val = WIDTH'($signed(op_q.imm8));
      2'b11: wb_val = op_q.mdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = '{rd: rd, rn: rn, rm: rm, shift_op: shift_op,
                      alu_op: alu_op, use_imm: use_imm, zero_a: zero_a,
                      wb_sel: wb_sel, wr_en: wr_en, upd_status: upd_status,
                      imm5: imm5, imm8: imm8, pc: pc, mdata: mdata};
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        a_d     = regs_q[op_q.rn];
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = regs_q[op_q.rm];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (op_q.upd_status) begin
          z_d = (alu_res == '0);
          n_d = alu_res[WIDTH-1];
          v_d = alu_v;
        end
        state_d = S_WB;
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the edge, independent of order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the register file is cleared on reset, so it is built from
      // flops rather than a RAM macro that has no reset.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      done_q  <= done_d;
      // Single write port; both operand reads happened in earlier states, so
      // rd may alias rn or rm safely.
      if (state_q == S_WB && op_q.wr_en) regs_q[op_q.rd] <= wb_val;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = c_q;
  assign Z_out    = z_q;
  assign N_out    = n_q;
  assign V_out    = v_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_seq_datapath.sv
`timescale 1ns / 1ps
module tb_seq_datapath;

  localparam int W  = 16;
  localparam int NR = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   rd, rn, rm, dbg_addr;
  logic [1:0]   shift_op, alu_op, wb_sel;
  logic         use_imm, zero_a, wr_en, upd_status;
  logic [4:0]   imm5;
  logic [7:0]   imm8, pc;
  logic [W-1:0] mdata;
  logic         busy, done, Z_out, N_out, V_out;
  logic [W-1:0] result, dbg_data;

  int vectors    = 0;
  int miscompares = 0;

  seq_datapath dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .rn(rn), .rm(rm),
    .shift_op(shift_op), .alu_op(alu_op), .use_imm(use_imm), .zero_a(zero_a),
    .wb_sel(wb_sel), .wr_en(wr_en), .upd_status(upd_status), .imm5(imm5),
    .imm8(imm8), .pc(pc), .mdata(mdata), .busy(busy), .done(done),
    .result(result), .Z_out(Z_out), .N_out(N_out), .V_out(V_out),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0] rd, rn, rm;
    logic [1:0] shift_op, alu_op, wb_sel;
    logic       use_imm, zero_a, wr_en, upd_status;
    logic [4:0] imm5;
    logic [7:0] imm8, pc;
    logic [15:0] mdata;
  } op_t;

  // Reference model: architectural state only.
  int m_reg [NR];
  int m_c;
  bit m_z, m_n, m_v;

  function automatic int to_signed(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  task automatic model_exec(input op_t o);
    int a, b, r, s, rv, i5, i8;
    bit v;
    a  = o.zero_a ? 0 : m_reg[o.rn];
    rv = m_reg[o.rm];
    i5 = int'(o.imm5);
    i8 = int'(o.imm8);
    if (o.use_imm) b = (i5 >= 16) ? i5 + 65536 - 32 : i5;
    else case (o.shift_op)
      2'd0: b = rv;
      2'd1: b = (rv * 2) % 65536;
      2'd2: b = rv / 2;
      default: b = rv / 2 + ((rv >= 32768) ? 32768 : 0);
    endcase
    v = 0;
    case (o.alu_op)
      2'd0: begin
        r = (a + b) % 65536;
        s = to_signed(a) + to_signed(b);
        v = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        r = (a - b + 65536) % 65536;
        s = to_signed(a) - to_signed(b);
        v = (s > 32767) || (s < -32768);
      end
      2'd2: r = a & b;
      default: r = 65535 - b;
    endcase
    m_c = r;
    if (o.upd_status) begin
      m_z = (r == 0);
      m_n = (r >= 32768);
      m_v = v;
    end
    if (o.wr_en) case (o.wb_sel)
      2'd0: m_reg[o.rd] = r;
      2'd1: m_reg[o.rd] = int'(o.pc);
      2'd2: m_reg[o.rd] = (i8 >= 128) ? i8 + 65536 - 256 : i8;
      default: m_reg[o.rd] = int'(o.mdata);
    endcase
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.rd = 3'($urandom);       o.rn = 3'($urandom);     o.rm = 3'($urandom);
    o.shift_op = 2'($urandom); o.alu_op = 2'($urandom); o.wb_sel = 2'($urandom);
    o.use_imm = 1'($urandom);  o.zero_a = 1'($urandom);
    o.wr_en = 1'($urandom);    o.upd_status = 1'($urandom);
    o.imm5 = 5'($urandom);     o.imm8 = 8'($urandom);   o.pc = 8'($urandom);
    o.mdata = 16'($urandom);
    return o;
  endfunction

  function automatic op_t blank_op();
    op_t o;
    o = '{rd: 3'd0, rn: 3'd0, rm: 3'd0, shift_op: 2'd0, alu_op: 2'd0,
          wb_sel: 2'd0, use_imm: 1'b0, zero_a: 1'b0, wr_en: 1'b0,
          upd_status: 1'b0, imm5: 5'd0, imm8: 8'd0, pc: 8'd0, mdata: 16'd0};
    return o;
  endfunction

  task automatic drive(input op_t o);
    rd = o.rd; rn = o.rn; rm = o.rm; shift_op = o.shift_op; alu_op = o.alu_op;
    wb_sel = o.wb_sel; use_imm = o.use_imm; zero_a = o.zero_a; wr_en = o.wr_en;
    upd_status = o.upd_status; imm5 = o.imm5; imm8 = o.imm8; pc = o.pc;
    mdata = o.mdata;
  endtask

  // Compare every register, C and the flags against the model.
  task automatic check_state(input string tag);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 3'(i);
      #1;
      vectors++;
      if (int'(dbg_data) !== m_reg[i]) begin
        miscompares++;
        $display("FAIL %s reg%0d: got %h expected %h", tag, i, dbg_data, 16'(m_reg[i]));
      end
    end
    vectors++;
    if (int'(result) !== m_c || {Z_out, N_out, V_out} !== {m_z, m_n, m_v}) begin
      miscompares++;
      $display("FAIL %s result/ZNV: got %h/%b%b%b expected %h/%b%b%b", tag,
               result, Z_out, N_out, V_out, 16'(m_c), m_z, m_n, m_v);
    end
  endtask

  // One operation: accept, scramble inputs, check handshake timing and state.
  task automatic run_op(input op_t o, input string tag);
    @(negedge clk);
    drive(o);
    start = 1'b1;
    model_exec(o);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        drive(rand_op());
      end
      vectors++;
      if (busy !== (cyc <= 4) || done !== (cyc == 5)) begin
        miscompares++;
        $display("FAIL %s handshake cyc%0d: got busy=%b done=%b expected busy=%b done=%b",
                 tag, cyc, busy, done, cyc <= 4, cyc == 5);
      end
      if (cyc == 4) begin
        vectors++;
        if (int'(result) !== m_c) begin
          miscompares++;
          $display("FAIL %s early result: got %h expected %h", tag, result, 16'(m_c));
        end
      end
      if (cyc == 5) check_state(tag);
    end
  endtask

  task automatic test_reset();
    check_state("reset");
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset busy/done: got %b/%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_imm_load();
    op_t o;
    o = blank_op(); o.wb_sel = 2'b10; o.imm8 = 8'hF6; o.rd = 3'd3; o.wr_en = 1'b1;
    run_op(o, "imm8_load");
    dbg_addr = 3'd3; #1;
    vectors++;
    if (dbg_data !== 16'hFFF6) begin
      miscompares++;
      $display("FAIL imm8_const: got %h expected fff6", dbg_data);
    end
    o = blank_op(); o.wb_sel = 2'b01; o.pc = 8'h2A; o.rd = 3'd4; o.wr_en = 1'b1;
    run_op(o, "pc_load");
    dbg_addr = 3'd4; #1;
    vectors++;
    if (dbg_data !== 16'h002A) begin
      miscompares++;
      $display("FAIL pc_const: got %h expected 002a", dbg_data);
    end
  endtask

  task automatic test_reset_mid_op();
    op_t o;
    o = blank_op(); o.wb_sel = 2'b10; o.imm8 = 8'h55; o.rd = 3'd2; o.wr_en = 1'b1;
    o.upd_status = 1'b1; o.alu_op = 2'b11;
    @(negedge clk);
    drive(o);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);              // now in EXEC
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_op cyc%0d: got busy=%b done=%b expected 0/0", cyc, busy, done);
      end
    end
    check_state("reset_mid_op");
  endtask

  task automatic load_mem(input logic [2:0] r, input logic [15:0] v, input string tag);
    op_t o;
    o = blank_op(); o.wb_sel = 2'b11; o.mdata = v; o.rd = r; o.wr_en = 1'b1;
    run_op(o, tag);
  endtask

  task automatic test_add_overflow();
    op_t o;
    load_mem(3'd1, 16'h7FFF, "ld_r1");
    load_mem(3'd2, 16'h0001, "ld_r2");
    o = blank_op(); o.rd = 3'd5; o.rn = 3'd1; o.rm = 3'd2; o.wr_en = 1'b1; o.upd_status = 1'b1;
    run_op(o, "add_ovf");
    dbg_addr = 3'd5; #1;
    vectors++;
    if (dbg_data !== 16'h8000 || {Z_out, N_out, V_out} !== 3'b011) begin
      miscompares++;
      $display("FAIL add_ovf_const: got %h ZNV=%b%b%b expected 8000 ZNV=011",
               dbg_data, Z_out, N_out, V_out);
    end
  endtask

  task automatic test_cmp();
    op_t o;
    load_mem(3'd1, 16'h1234, "ld_r1");
    load_mem(3'd2, 16'h1234, "ld_r2");
    o = blank_op(); o.rn = 3'd1; o.rm = 3'd2; o.alu_op = 2'b01; o.upd_status = 1'b1;
    o.rd = 3'd1;
    run_op(o, "cmp");
    vectors++;
    if (result !== 16'h0000 || {Z_out, N_out, V_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL cmp_const: got %h ZNV=%b%b%b expected 0000 ZNV=100",
               result, Z_out, N_out, V_out);
    end
  endtask

  task automatic test_shift_imm();
    op_t o;
    logic [15:0] exp_v [3] = '{16'hC001, 16'h4001, 16'hFFF0};
    load_mem(3'd2, 16'h8002, "ld_r2");
    load_mem(3'd1, 16'h0000, "ld_r1");
    for (int k = 0; k < 3; k++) begin
      o = blank_op(); o.rm = 3'd2; o.rn = 3'd1;
      if (k == 0) begin o.shift_op = 2'b11; o.zero_a = 1'b1; end
      if (k == 1) begin o.shift_op = 2'b10; o.zero_a = 1'b1; end
      if (k == 2) begin o.use_imm = 1'b1; o.imm5 = 5'b10000; end
      run_op(o, "shift_imm");
      vectors++;
      if (result !== exp_v[k]) begin
        miscompares++;
        $display("FAIL shift_imm_const%0d: got %h expected %h", k, result, exp_v[k]);
      end
    end
  endtask

  task automatic test_hazard();
    op_t o;
    o = blank_op(); o.wb_sel = 2'b10; o.imm8 = 8'h10; o.rd = 3'd6; o.wr_en = 1'b1;
    run_op(o, "ld_r6");
    o = blank_op(); o.rd = 3'd6; o.rn = 3'd6; o.use_imm = 1'b1; o.imm5 = 5'd1;
    o.wr_en = 1'b1;
    run_op(o, "inc_r6_a");
    run_op(o, "inc_r6_b");
    dbg_addr = 3'd6; #1;
    vectors++;
    if (dbg_data !== 16'h0012) begin
      miscompares++;
      $display("FAIL hazard_const: got %h expected 0012", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    op_t o;
    int dones, c1, c2;
    o = blank_op(); o.rd = 3'd7; o.rn = 3'd7; o.use_imm = 1'b1; o.imm5 = 5'd1;
    o.wr_en = 1'b1; o.upd_status = 1'b1;
    model_exec(o); c1 = m_c;
    model_exec(o); c2 = m_c;
    dones = 0;
    @(negedge clk);
    drive(o);
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 10) start = 1'b0;
      if (done === 1'b1) dones++;
      vectors++;
      if (busy !== (cyc <= 10 && cyc % 5 != 0) || done !== (cyc <= 10 && cyc % 5 == 0)) begin
        miscompares++;
        $display("FAIL b2b handshake cyc%0d: got busy=%b done=%b", cyc, busy, done);
      end
      if (cyc == 4 || cyc == 9) begin
        vectors++;
        if (int'(result) !== ((cyc == 4) ? c1 : c2)) begin
          miscompares++;
          $display("FAIL b2b result cyc%0d: got %h expected %h", cyc, result,
                   16'((cyc == 4) ? c1 : c2));
        end
      end
    end
    vectors++;
    if (dones !== 2) begin
      miscompares++;
      $display("FAIL b2b done_count: got %0d expected 2", dones);
    end
    check_state("b2b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) run_op(rand_op(), "random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dbg_addr = 3'd0;
    drive(blank_op());
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_imm_load();
    test_reset_mid_op();
    test_add_overflow();
    test_cmp();
    test_shift_imm();
    test_hazard();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
